lc3_mem_arbiter: RTL
====================

Name: lc3_mem_arbiter

Overview:
- Shares one external single-port memory between the LC3 fetch requester and the MemAccess requester.
- Converts each requester's level request into a mem_req/mem_ack transaction on the shared port.
- Returns a one-cycle complete pulse and registered read data to the winning requester.
- Sits between the LC3 core ports (instruction and data sides) and the memory model; feeds complete_instr/complete_data to the pipeline controller.

Parameters:
- MAX_CONSEC, 3: maximum consecutive data grants while an instruction request is pending; afterwards the instruction side wins once.
- TIMEOUT, 64: cycles in a BUSY state without mem_ack before abort (used only with the optional feature).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-low reset
- instrmem_rd  input  1  instruction read request (level)
- pc  input  16  instruction address
- Data_req  input  1  data access request (level)
- Data_rd  input  1  1=read, 0=write
- Data_addr  input  16  data address
- Data_din  input  16  write data
- Instr_dout  output  16  registered instruction read data
- Data_dout  output  16  registered data read data
- complete_instr  output  1  one-cycle instruction completion pulse
- complete_data  output  1  one-cycle data completion pulse
- mem_req  output  1  shared-port request
- mem_we  output  1  shared-port write enable
- mem_addr  output  16  shared-port address
- mem_wdata  output  16  shared-port write data
- mem_rdata  input  16  shared-port read data, valid with mem_ack
- mem_ack  input  1  shared-port acknowledge
- mem_err  output  1  sticky timeout error

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, including Instr_dout and Data_dout.
  - The consecutive-grant counter clears.
- Reset applied mid-transaction: mem_req drops on that edge; a later mem_ack for the abandoned access is ignored.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE:
  - Samples the requests at each edge.
  - Data_req only → BUSY_D. instrmem_rd only → BUSY_I.
  - Both high → BUSY_D, unless consec_cnt==MAX_CONSEC, in which case → BUSY_I.
  - On the transition, the arbiter latches into output registers: mem_addr (Data_addr or pc), mem_wdata=Data_din, mem_we=~Data_rd (always 0 for instruction), and mem_req=1.
- consec_cnt:
  - Increments on a data grant made while instrmem_rd==1, saturating at MAX_CONSEC.
  - Clears on any instruction grant.
  - Clears on a data grant made with instrmem_rd==0.
- BUSY_x:
  - mem_req, mem_addr, mem_we and mem_wdata stay stable.
  - Requester inputs are ignored.
  - On an edge with mem_ack==1: mem_req←0, mem_we←0, and state → RESP_x.
  - For reads, the matching dout captures mem_rdata on that edge.
  - For writes, Data_dout is unchanged.
- RESP_x:
  - complete_x=1 for exactly this cycle; next state IDLE.
  - The requester must drop its request on the edge ending RESP_x; a request still high in IDLE starts a new access.
- mem_ack seen in IDLE or RESP states is ignored.
- Latency: request seen at IDLE edge t → mem_req high from t+1 → ack at edge t+k (k≥1) → complete high in cycle t+k → IDLE at t+k+1.
  - Minimum request-to-complete is 2 edges.
  - Back-to-back throughput is one access per k+2 cycles.
- Instr_dout and Data_dout hold their value until the next read completion on their own side.
- complete_instr and complete_data are never high in the same cycle.

Optional Feature:
- Macro: LC3_MEM_TIMEOUT_EN.
- When defined:
  - A counter runs in BUSY_x, cleared on entry.
  - If TIMEOUT cycles elapse without mem_ack: mem_req←0, the matching dout←16'h0000 (reads only), state → RESP_x (so complete still pulses), and mem_err←1.
  - mem_err is sticky until reset.
  - An ack arriving on the same edge that the count reaches TIMEOUT takes priority, and no error is flagged.
- When undefined: BUSY waits indefinitely; mem_err is tied to 0 and no counter logic exists.

Test Plan:
- Instruction read: instrmem_rd=1, pc=16'h3000, mem_ack after 1 cycle with mem_rdata=16'h1234 → mem_addr=16'h3000, mem_we=0, complete_instr pulses once, Instr_dout=16'h1234.
- Simultaneous requests: Data_req=1, Data_rd=1, Data_addr=16'h4000 and instrmem_rd=1 in the same cycle → data served first (mem_addr=16'h4000); instruction served next with mem_addr=pc.
- Data write: Data_rd=0, Data_addr=16'h5000, Data_din=16'hBEEF, ack after 3 cycles → mem_we=1, mem_wdata=16'hBEEF held for 3 cycles, complete_data pulses, Data_dout unchanged.
- Starvation: MAX_CONSEC=3, Data_req and instrmem_rd held high continuously → grant order D,D,D,I,D,D,D,I.
- Reset mid-access: reset=0 while in BUSY_D → mem_req=0 next edge; a stale ack after reset release produces no complete pulse.
- Timeout (LC3_MEM_TIMEOUT_EN, TIMEOUT=8): no mem_ack → complete_instr pulses after 8 BUSY cycles, Instr_dout=16'h0000, mem_err=1 until reset.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// Two-requester arbiter (instruction fetch / MemAccess) for one shared single-port memory.
// Optional BUSY-state watchdog with sticky mem_err is built when LC3_MEM_TIMEOUT_EN is defined.
module lc3_mem_arbiter #(
    parameter int unsigned MAX_CONSEC = 3
`ifdef LC3_MEM_TIMEOUT_EN
    , parameter int unsigned TIMEOUT = 64
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instrmem_rd,
    input  logic [15:0] pc,
    input  logic        Data_req,
    input  logic        Data_rd,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    output logic [15:0] Instr_dout,
    output logic [15:0] Data_dout,
    output logic        complete_instr,
    output logic        complete_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_err
);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_e;

    localparam int unsigned   CW   = (MAX_CONSEC < 1) ? 1 : $clog2(MAX_CONSEC + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_CONSEC);

    state_e        state_q, state_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [15:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [15:0]   idout_q, idout_d;
    logic [15:0]   ddout_q, ddout_d;
    logic [CW-1:0] consec_q, consec_d;
    logic          grant_data;

`ifdef LC3_MEM_TIMEOUT_EN
    localparam int unsigned   TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
`endif

    // Data normally wins; a pending fetch takes one turn once the data streak saturates.
    assign grant_data = Data_req && !(instrmem_rd && (consec_q == CMAX));

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        idout_d  = idout_q;
        ddout_d  = ddout_q;
        consec_d = consec_q;
`ifdef LC3_MEM_TIMEOUT_EN
        tcnt_d   = tcnt_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (Data_req || instrmem_rd) begin
                    req_d   = 1'b1;
                    wdata_d = Data_din;
`ifdef LC3_MEM_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                    if (grant_data) begin
                        state_d = BUSY_D;
                        addr_d  = Data_addr;
                        we_d    = ~Data_rd;
                        if (!instrmem_rd)
                            consec_d = '0;
                        else if (consec_q != CMAX)
                            consec_d = consec_q + 1'b1;
                    end else begin
                        state_d  = BUSY_I;
                        addr_d   = pc;
                        we_d     = 1'b0;
                        consec_d = '0;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = (state_q == BUSY_I) ? RESP_I : RESP_D;
                    if (state_q == BUSY_I)
                        idout_d = mem_rdata;
                    else if (!we_q)
                        ddout_d = mem_rdata;
                end
`ifdef LC3_MEM_TIMEOUT_EN
                else if (tcnt_q == TLAST) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    state_d = (state_q == BUSY_I) ? RESP_I : RESP_D;
                    if (state_q == BUSY_I)
                        idout_d = '0;
                    else if (!we_q)
                        ddout_d = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
`endif
            end
            RESP_I, RESP_D: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            idout_q  <= '0;
            ddout_q  <= '0;
            consec_q <= '0;
`ifdef LC3_MEM_TIMEOUT_EN
            tcnt_q   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            idout_q  <= idout_d;
            ddout_q  <= ddout_d;
            consec_q <= consec_d;
`ifdef LC3_MEM_TIMEOUT_EN
            tcnt_q   <= tcnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign mem_req        = req_q;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign Instr_dout     = idout_q;
    assign Data_dout      = ddout_q;
    assign complete_instr = (state_q == RESP_I);
    assign complete_data  = (state_q == RESP_D);
`ifdef LC3_MEM_TIMEOUT_EN
    assign mem_err        = err_q;
`else
    assign mem_err        = 1'b0;
`endif

endmodule
